mul_err_tracker: RTL

MUL_ERR_TRACKER -- requirements
Module: mul_err_tracker

---
 rtl/mul_err_tracker.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mul_err_tracker.sv
// Error tracker for an approximate multiplier: drives operand pairs, samples the result after
// SETTLE cycles, and keeps error statistics. Define MUL_ERR_SUM_EN to build the err_sum accumulator.
module mul_err_tracker #(
  parameter int WIDTH  = 6,
  parameter int SETTLE = 1,
  parameter int SUMW   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    src_valid,
  output logic                    src_ready,
  input  logic [WIDTH-1:0]        src_a,
  input  logic [WIDTH-1:0]        src_b,
  output logic [WIDTH-1:0]        mul_in1,
  output logic [WIDTH-1:0]        mul_in2,
  input  logic [2*WIDTH-1:0]      mul_out,
  input  logic                    mul_ovf,
  output logic                    res_valid,
  output logic [2*WIDTH-1:0]      res_approx,
  output logic [2*WIDTH-1:0]      res_exact,
  output logic signed [2*WIDTH:0] res_err,
  input  logic                    clear,
  output logic [31:0]             cnt_total,
  output logic [31:0]             cnt_wrong,
  output logic [2*WIDTH-1:0]      err_max,
  output logic [SUMW-1:0]         err_sum
);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, UPDATE} state_t;

  state_t             state;
  logic [3:0]         settle_cnt;
  logic [PW-1:0]      approx_q, exact_q;
  logic               ovf_q;
  logic signed [PW:0] err_c;
  logic [PW-1:0]      abs_c;
  logic               wrong_c;

  // Both products are unsigned PW-bit values, so one extra bit holds any signed difference.
  assign err_c   = $signed({1'b0, exact_q}) - $signed({1'b0, approx_q});
  assign abs_c   = err_c[PW] ? PW'(-err_c) : err_c[PW-1:0];
  assign wrong_c = (err_c != '0) || ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      src_ready  <= 1'b1;
      settle_cnt <= '0;
      mul_in1    <= '0;
      mul_in2    <= '0;
      approx_q   <= '0;
      exact_q    <= '0;
      ovf_q      <= 1'b0;
      res_valid  <= 1'b0;
      res_approx <= '0;
      res_exact  <= '0;
      res_err    <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: if (src_valid && src_ready) begin
          mul_in1    <= src_a;
          mul_in2    <= src_b;
          settle_cnt <= 4'(SETTLE - 1);
          src_ready  <= 1'b0;
          state      <= DRIVE;
        end
        DRIVE: begin
          if (settle_cnt == '0) state <= SAMPLE;
          else settle_cnt <= settle_cnt - 4'd1;
        end
        SAMPLE: begin
          approx_q <= mul_out;
          exact_q  <= PW'(mul_in1) * PW'(mul_in2);
          ovf_q    <= mul_ovf;
          state    <= UPDATE;
        end
        UPDATE: begin
          res_valid  <= 1'b1;
          res_approx <= approx_q;
          res_exact  <= exact_q;
          res_err    <= err_c;
          src_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // clear has priority over an UPDATE in the same cycle; the FSM is untouched by it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_total <= '0;
      cnt_wrong <= '0;
      err_max   <= '0;
    end else if (clear) begin
      cnt_total <= '0;
      cnt_wrong <= '0;
      err_max   <= '0;
    end else if (state == UPDATE) begin
      if (cnt_total != '1) cnt_total <= cnt_total + 32'd1;
      if (wrong_c && cnt_wrong != '1) cnt_wrong <= cnt_wrong + 32'd1;
      if (abs_c > err_max) err_max <= abs_c;
    end
  end

`ifdef MUL_ERR_SUM_EN
  logic [SUMW:0] sum_nx;
  assign sum_nx = {1'b0, err_sum} + (SUMW+1)'(abs_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 err_sum <= '0;
    else if (clear)          err_sum <= '0;
    else if (state == UPDATE) err_sum <= sum_nx[SUMW] ? '1 : sum_nx[SUMW-1:0];
  end
`else
  assign err_sum = '0;
`endif

endmodule
